// File: rtl/data_packer.sv
// rtl/data_packer.sv - multi-channel byte-to-word packer with flush and skid-free output register
`timescale 1ns/1ps

module data_packer #(
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int CHANNELS       = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  input  logic [CHANNELS*BYTE_W-1:0]                  in_data,
  output logic                                        in_ready,
  input  logic                                        flush,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [CHANNELS*BYTES_PER_WORD*BYTE_W-1:0]   out_data,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]         out_count,
  output logic [15:0]                                 word_cnt
);

  localparam int BPW    = BYTES_PER_WORD;
  localparam int WORD_W = BPW * BYTE_W;
  localparam int OUT_W  = CHANNELS * WORD_W;
  localparam int CNT_W  = $clog2(BPW + 1);
  localparam int IDX_W  = $clog2(BPW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  // Slot index, pending flush and the accumulator (same layout as out_data)
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             flush_pend_q, flush_pend_d;
  logic [OUT_W-1:0] acc_q, acc_d, acc_merged;

  // Output register and emitted-word counter
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [15:0]      word_cnt_q, word_cnt_d;

  logic             at_last;
  logic             out_free;
  logic             accept;
  logic             load;
  logic [CNT_W-1:0] fill;

  // The output register can take a new word if it is empty or draining now.
  assign at_last  = (idx_q == LAST_IDX);
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = !flush_pend_q && !(at_last && !out_free);
  assign accept   = in_valid && in_ready;
  assign fill     = CNT_W'(idx_q) + CNT_W'(accept);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign word_cnt  = word_cnt_q;

  // Accumulator contents including a byte set accepted this cycle
  always_comb begin
    acc_merged = acc_q;
    if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_merged[c*WORD_W + int'(idx_q)*BYTE_W +: BYTE_W] = in_data[c*BYTE_W +: BYTE_W];
      end
    end
  end

  // Next-state: completion, pending flush, new flush and output drain
  always_comb begin
    idx_d        = idx_q;
    flush_pend_d = flush_pend_q;
    acc_d        = acc_merged;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    word_cnt_d   = word_cnt_q;
    load         = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      word_cnt_d  = word_cnt_q + 16'd1;
    end

    if (accept) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (accept && at_last) begin
      // A full word absorbs any flush arriving with its last byte.
      load = 1'b1;
    end else if (flush_pend_q) begin
      if (out_free) begin
        load         = 1'b1;
        flush_pend_d = 1'b0;
      end
    end else if (flush && (fill != '0)) begin
      if (out_free) begin
        load = 1'b1;
      end else begin
        flush_pend_d = 1'b1;
      end
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_merged;
      out_count_d = fill;
      acc_d       = '0;
      idx_d       = '0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      flush_pend_q <= 1'b0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      word_cnt_q   <= '0;
    end else begin
      idx_q        <= idx_d;
      flush_pend_q <= flush_pend_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_data_packer.sv
// tb/tb_data_packer.sv - scoreboard bench for data_packer with stream-level reference model
`timescale 1ns/1ps

module tb_data_packer;

  localparam int BYTE_W = 8;
  localparam int BPW    = 4;
  localparam int CH     = 2;
  localparam int WORD_W = BPW * BYTE_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [2:0]  out_count;
  logic [15:0] word_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  count;
  } word_t;

  word_t       exp_q[$];
  logic [15:0] part_q[$];
  logic [15:0] exp_wc = '0;

  data_packer #(.BYTE_W(BYTE_W), .BYTES_PER_WORD(BPW), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: bytes accumulate in arrival order; a word closes at BPW bytes or on flush.
  function automatic void close_word();
    word_t       w;
    logic [15:0] set;
    w.data  = '0;
    w.count = 3'(part_q.size());
    for (int k = 0; k < part_q.size(); k++) begin
      set = part_q[k];
      for (int c = 0; c < CH; c++) begin
        w.data[c*WORD_W + k*BYTE_W +: BYTE_W] = set[c*BYTE_W +: BYTE_W];
      end
    end
    exp_q.push_back(w);
    part_q.delete();
  endfunction

  task automatic drive_cycle(input bit v, input logic [15:0] d, input bit f, input bit ordy,
                             output bit accepted);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = ordy;
    @(negedge clk);
    accepted = v && in_ready;
    if (accepted) begin
      part_q.push_back(d);
      if (part_q.size() == BPW) close_word();
    end
    if (f && part_q.size() != 0) close_word();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input bit ordy);
    bit a;
    int tries;
    tries = 0;
    a = 1'b0;
    while (!a && tries < 30) begin
      drive_cycle(1'b1, d, 1'b0, ordy, a);
      tries++;
    end
    if (!a) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no accept expected accept within 30 cycles");
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'h0, 1'b0, ordy, a);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    exp_q.delete();
    part_q.delete();
    exp_wc = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops expected words on each handshake and checks hold stability
  initial begin
    word_t       w;
    bit          held;
    logic [63:0] hd;
    logic [2:0]  hc;
    held = 1'b0;
    hd = '0;
    hc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hd);
        check("hold_count", out_count, hc);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got data %h count %0d expected no word", out_data, out_count);
        end else begin
          w = exp_q.pop_front();
          check("word_data", out_data, w.data);
          check("word_count", out_count, w.count);
        end
        check("word_cnt", word_cnt, exp_wc);
        exp_wc = exp_wc + 16'd1;
      end
      held = out_valid && !out_ready;
      hd   = out_data;
      hc   = out_count;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: got no finish expected finish before 1500000ns");
    $fatal(1, "timeout");
  end

  initial begin
    bit a;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("init_out_valid", out_valid, 0);
    check("init_out_data", out_data, 0);
    check("init_out_count", out_count, 0);
    check("init_word_cnt", word_cnt, 0);
    rst = 1'b0;
    #1;
    check("init_in_ready", in_ready, 1);

    // Basic full word
    send({8'hAA, 8'h11}, 1'b1);
    send({8'hBB, 8'h22}, 1'b1);
    send({8'hCC, 8'h33}, 1'b1);
    send({8'hDD, 8'h44}, 1'b1);
    check("basic_valid", out_valid, 1);
    check("basic_data", out_data, 64'hDDCCBBAA_44332211);
    check("basic_count", out_count, 4);
    idle(1, 1'b1);
    check("basic_one_cycle", out_valid, 0);
    check("basic_word_cnt", word_cnt, 1);

    // Backpressure: first word held, slot 3 blocked, then back-to-back
    for (int i = 0; i < 7; i++) send(16'(16'h0101 * (i + 1)), 1'b0);
    check("stall_in_ready", in_ready, 0);
    drive_cycle(1'b1, 16'h0808, 1'b0, 1'b0, a);
    check("stall_no_accept", a, 0);
    drive_cycle(1'b1, 16'h0808, 1'b0, 1'b1, a);
    check("stall_release_accept", a, 1);
    check("b2b_valid", out_valid, 1);
    check("b2b_count", out_count, 4);
    idle(3, 1'b1);

    // Partial flush, then flush at idx 0
    send({8'h00, 8'h01}, 1'b1);
    send({8'h00, 8'h02}, 1'b1);
    drive_cycle(1'b0, 16'h0, 1'b1, 1'b1, a);
    check("partial_valid", out_valid, 1);
    check("partial_data", out_data, 64'h00000000_00000201);
    check("partial_count", out_count, 2);
    idle(1, 1'b1);
    drive_cycle(1'b0, 16'h0, 1'b1, 1'b1, a);
    idle(1, 1'b1);
    check("empty_flush_no_word", out_valid, 0);

    // Flush while output held
    for (int i = 0; i < 6; i++) send(16'(16'h1111 * (i + 1)), 1'b0);
    drive_cycle(1'b0, 16'h0, 1'b1, 1'b0, a);
    check("pend_in_ready", in_ready, 0);
    drive_cycle(1'b1, 16'h7777, 1'b0, 1'b0, a);
    check("pend_no_accept", a, 0);
    idle(4, 1'b1);
    check("pend_drained", exp_q.size(), 0);

    // Async reset mid-word with held output
    for (int i = 0; i < 6; i++) send(16'(16'h2121 * (i + 1)), 1'b0);
    do_reset();
    idle(2, 1'b1);
    check("post_rst_no_word", out_valid, 0);
    send(16'hA1B1, 1'b1);
    send(16'hA2B2, 1'b1);
    send(16'hA3B3, 1'b1);
    send(16'hA4B4, 1'b1);
    check("post_rst_data", out_data, 64'hA4A3A2A1_B4B3B2B1);
    idle(1, 1'b1);
    check("post_rst_word_cnt", word_cnt, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive_cycle(($urandom % 4) != 0, 16'($urandom), ($urandom % 8) == 0, ($urandom % 3) != 0, a);
    end
    drive_cycle(1'b0, 16'h0, 1'b1, 1'b1, a);
    for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++) idle(1, 1'b1);
    check("random_drained", exp_q.size(), 0);

    // Counter wrap: one single-byte word per cycle
    do_reset();
    for (int i = 0; i < 65536; i++) drive_cycle(1'b1, 16'($urandom), 1'b1, 1'b1, a);
    idle(1, 1'b1);
    check("word_cnt_wrap", word_cnt, 0);
    check("wrap_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
